// File: rtl/sba_gpio.sv
// SBA GPIO slave: LED register, synchronised/debounced buttons, edge-pending flags, level IRQ.
// Define GPIO_FALL_EDGE_EN to add falling-edge pending/enable bits [N_BUT+15:16].
module sba_gpio #(
    parameter int unsigned N_BUT      = 2,
    parameter int unsigned N_LED      = 2,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stb,
    input  logic [3:0]       i_we,
    input  logic [3:0]       i_addr,
    input  logic [31:0]      i_dat_w,
    output logic [31:0]      o_dat_r,
    output logic             o_ack,
    input  logic [N_BUT-1:0] i_but,
    output logic [N_LED-1:0] o_led,
    output logic             o_int
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        RegLed  = 2'd0,
        RegBut  = 2'd1,
        RegPend = 2'd2,
        RegIe   = 2'd3
    } reg_e;

    reg_e        sel;
    logic        ack_q, ack_d;
    logic        done_q, done_d;
    logic        acc, wr_en;
    logic [31:0] dat_r_q, dat_r_d, rd_word;
    logic        int_q, int_d;

    logic [N_LED-1:0] led_q, led_d;
    logic [N_BUT-1:0] ie_rise_q, ie_rise_d;
    logic [N_BUT-1:0] pend_rise_q, pend_rise_d;
    logic [N_BUT-1:0] pend_fall, ie_fall;

    logic [N_BUT-1:0] sync1_q, sync2_q;
    logic [N_BUT-1:0] deb_q, deb_d;
    logic [N_BUT-1:0] rise, fall;
    logic [CW-1:0]    cnt_q [N_BUT];
    logic [CW-1:0]    cnt_d [N_BUT];

    // done_q blocks re-acceptance while the same strobe is still held after its ack.
    assign acc    = i_stb & ~ack_q & ~done_q;
    assign wr_en  = acc & (|i_we);
    assign sel    = reg_e'(i_addr[3:2]);
    assign ack_d  = acc;
    assign done_d = (ack_q | done_q) & i_stb;

    always_comb begin
        deb_d = deb_q;
        rise  = '0;
        fall  = '0;
        for (int i = 0; i < int'(N_BUT); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                    rise[i]  = sync2_q[i];
                    fall[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        led_d       = led_q;
        ie_rise_d   = ie_rise_q;
        pend_rise_d = pend_rise_q;
        if (wr_en && i_we[0]) begin
            unique case (sel)
                RegLed:  led_d       = i_dat_w[N_LED-1:0];
                RegPend: pend_rise_d = pend_rise_q & ~i_dat_w[N_BUT-1:0];
                RegIe:   ie_rise_d   = i_dat_w[N_BUT-1:0];
                default: ;
            endcase
        end
        // A new edge overrides a simultaneous clear.
        pend_rise_d = pend_rise_d | rise;
    end

    always_comb begin
        rd_word = '0;
        unique case (sel)
            RegLed:  rd_word[N_LED-1:0] = led_q;
            RegBut:  rd_word[N_BUT-1:0] = deb_q;
            RegPend: begin
                rd_word[N_BUT-1:0]  = pend_rise_q;
                rd_word[16 +: N_BUT] = pend_fall;
            end
            RegIe: begin
                rd_word[N_BUT-1:0]  = ie_rise_q;
                rd_word[16 +: N_BUT] = ie_fall;
            end
            default: ;
        endcase
    end

    assign dat_r_d = acc ? rd_word : dat_r_q;
    assign int_d   = |({pend_fall, pend_rise_q} & {ie_fall, ie_rise_q});

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            dat_r_q     <= '0;
            int_q       <= 1'b0;
            led_q       <= '0;
            ie_rise_q   <= '0;
            pend_rise_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            for (int i = 0; i < int'(N_BUT); i++) cnt_q[i] <= '0;
        end else begin
            ack_q       <= ack_d;
            done_q      <= done_d;
            dat_r_q     <= dat_r_d;
            int_q       <= int_d;
            led_q       <= led_d;
            ie_rise_q   <= ie_rise_d;
            pend_rise_q <= pend_rise_d;
            sync1_q     <= i_but;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            for (int i = 0; i < int'(N_BUT); i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef GPIO_FALL_EDGE_EN
    logic [N_BUT-1:0] pend_fall_q, pend_fall_d;
    logic [N_BUT-1:0] ie_fall_q, ie_fall_d;

    always_comb begin
        pend_fall_d = pend_fall_q;
        ie_fall_d   = ie_fall_q;
        if (wr_en && i_we[2]) begin
            if (sel == RegPend) pend_fall_d = pend_fall_q & ~i_dat_w[16 +: N_BUT];
            if (sel == RegIe)   ie_fall_d   = i_dat_w[16 +: N_BUT];
        end
        pend_fall_d = pend_fall_d | fall;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend_fall_q <= '0;
            ie_fall_q   <= '0;
        end else begin
            pend_fall_q <= pend_fall_d;
            ie_fall_q   <= ie_fall_d;
        end
    end

    assign pend_fall = pend_fall_q;
    assign ie_fall   = ie_fall_q;
`else
    assign pend_fall = '0;
    assign ie_fall   = '0;

    logic unused_fall;
    assign unused_fall = ^fall;
`endif

    logic unused_in;
    assign unused_in = ^{i_addr[1:0], i_we, i_dat_w};

    assign o_dat_r = dat_r_q;
    assign o_ack   = ack_q;
    assign o_led   = led_q;
    assign o_int   = int_q;

endmodule
